// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared widths, grant and arbiter state types for the read arbiter.
package axi_read_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_ADDR = 2'd1, ARB_DATA = 2'd2} arb_state_e;
  typedef enum logic {GRANT_M0 = 1'b0, GRANT_M1 = 1'b1} grant_e;
endpackage

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: reduced AXI bus (AR/R read, AW/W/B write) with master/slave views.
interface axi_interface;
  import axi_read_arbiter_pkg::*;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  modport master (
    output araddr, arlen, arvalid, rready, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arlen, arvalid, rready, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master single-burst AXI read arbiter, m1 priority with m0 anti-starvation.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  axi_interface.slave  axi_bus_m0,
  axi_interface.slave  axi_bus_m1,
  axi_interface.master axi_bus_s
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  arb_state_e    state_q, state_d;
  grant_e        grant_q, grant_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    beat_q, beat_d, len_q, len_d;
  logic          m1_sel, in_addr, in_data, ar_hs, r_hs, last_beat, pick_m0;
  assign m1_sel    = grant_q == GRANT_M1;
  assign in_addr   = state_q == ARB_ADDR;
  assign in_data   = state_q == ARB_DATA;
  assign ar_hs     = axi_bus_s.arvalid && axi_bus_s.arready;
  assign r_hs      = axi_bus_s.rvalid && axi_bus_s.rready;
  assign last_beat = beat_q == len_q;
  assign pick_m0   = axi_bus_m0.arvalid && (!axi_bus_m1.arvalid || starve_q == LIMIT);
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    beat_d   = beat_q;
    len_d    = len_q;
    case (state_q)
      ARB_IDLE: begin
        starve_d = (!axi_bus_m0.arvalid || pick_m0) ? '0 : starve_q + 1'b1;
        if (axi_bus_m0.arvalid || axi_bus_m1.arvalid) begin
          grant_d = pick_m0 ? GRANT_M0 : GRANT_M1;
          len_d   = pick_m0 ? axi_bus_m0.arlen : axi_bus_m1.arlen;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: state_d = ar_hs ? ARB_DATA : ARB_ADDR;
      ARB_DATA: begin
        beat_d  = r_hs ? (last_beat ? '0 : beat_q + 1'b1) : beat_q;
        state_d = (r_hs && last_beat) ? ARB_IDLE : ARB_DATA;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= GRANT_M0;
      starve_q <= '0;
      beat_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
    end
  end
  assign axi_bus_s.araddr    = m1_sel ? axi_bus_m1.araddr : axi_bus_m0.araddr;
  assign axi_bus_s.arlen     = m1_sel ? axi_bus_m1.arlen : axi_bus_m0.arlen;
  assign axi_bus_s.arvalid   = in_addr && (m1_sel ? axi_bus_m1.arvalid : axi_bus_m0.arvalid);
  assign axi_bus_m0.arready  = in_addr && !m1_sel && axi_bus_s.arready;
  assign axi_bus_m1.arready  = in_addr && m1_sel && axi_bus_s.arready;
  assign axi_bus_m0.rdata    = m1_sel ? '0 : axi_bus_s.rdata;
  assign axi_bus_m1.rdata    = m1_sel ? axi_bus_s.rdata : '0;
  assign axi_bus_m0.rvalid   = in_data && !m1_sel && axi_bus_s.rvalid;
  assign axi_bus_m1.rvalid   = in_data && m1_sel && axi_bus_s.rvalid;
  assign axi_bus_s.rready    = in_data && (m1_sel ? axi_bus_m1.rready : axi_bus_m0.rready);
  // Only the CPU writes; the display DMA write side is held permanently not-ready.
  assign axi_bus_s.awaddr    = axi_bus_m0.awaddr;
  assign axi_bus_s.awlen     = axi_bus_m0.awlen;
  assign axi_bus_s.awvalid   = axi_bus_m0.awvalid;
  assign axi_bus_s.wdata     = axi_bus_m0.wdata;
  assign axi_bus_s.wlast     = axi_bus_m0.wlast;
  assign axi_bus_s.wvalid    = axi_bus_m0.wvalid;
  assign axi_bus_s.bready    = axi_bus_m0.bready;
  assign axi_bus_m0.awready  = axi_bus_s.awready;
  assign axi_bus_m0.wready   = axi_bus_s.wready;
  assign axi_bus_m0.bresp    = axi_bus_s.bresp;
  assign axi_bus_m0.bvalid   = axi_bus_s.bvalid;
  assign axi_bus_m1.awready  = 1'b0;
  assign axi_bus_m1.wready   = 1'b0;
  assign axi_bus_m1.bresp    = 2'b00;
  assign axi_bus_m1.bvalid   = 1'b0;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: random masters and memory slave checked against a transaction-level arbitration model.
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;
  localparam int LIMIT = 4;
  typedef struct {logic [31:0] addr; logic [7:0] len;} req_t;
  typedef struct {logic [7:0] len; logic [7:0] beat; logic [23:0] tag;} burst_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  axi_interface m0 ();
  axi_interface m1 ();
  axi_interface s ();
  axi_read_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .axi_bus_m0(m0), .axi_bus_m1(m1), .axi_bus_s(s)
  );
  int n_cmp = 0, n_bad = 0;
  req_t q0[$], q1[$];
  burst_t sq[$];
  bit gnt_log[$];
  bit busy, aph, win, stall, pend;
  int starve, left, beats0, beats1, ar_wait, last_wait;
  logic [31:0] exp_addr, pa;
  logic [7:0] exp_len, pl;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic quiet();
    {m0.arvalid, m0.araddr, m0.arlen, m0.rready, m0.awaddr, m0.awlen, m0.awvalid} = '0;
    {m0.wdata, m0.wlast, m0.wvalid, m0.bready} = '0;
    {m1.arvalid, m1.araddr, m1.arlen, m1.rready, m1.awaddr, m1.awlen, m1.awvalid} = '0;
    {m1.wdata, m1.wlast, m1.wvalid, m1.bready} = '0;
    {s.arready, s.rvalid, s.rdata, s.awready, s.wready, s.bvalid, s.bresp} = '0;
  endtask
  a_m0_hold: assert property (@(posedge clk) disable iff (reset)
    m0.arvalid && !m0.arready |=> m0.arvalid && $stable(m0.araddr) && $stable(m0.arlen));
  a_m1_hold: assert property (@(posedge clk) disable iff (reset)
    m1.arvalid && !m1.arready |=> m1.arvalid && $stable(m1.araddr) && $stable(m1.arlen));
  initial begin
    quiet();
    forever begin
      @(posedge clk);
      #1;
      if (reset) quiet();
      else begin
        m0.arvalid = q0.size() != 0;
        if (q0.size() != 0) {m0.araddr, m0.arlen} = {q0[0].addr, q0[0].len};
        m1.arvalid = q1.size() != 0;
        if (q1.size() != 0) {m1.araddr, m1.arlen} = {q1[0].addr, q1[0].len};
        m0.rready = $urandom_range(0, 3) != 0;
        m1.rready = $urandom_range(0, 3) != 0;
        s.arready = stall ? (ar_wait >= 10) : 1'($urandom);
        s.rvalid  = $urandom_range(0, 3) != 0;
        s.rdata   = sq.size() != 0 ? {sq[0].tag, sq[0].beat} : $urandom;
        {m0.awaddr, m0.wdata} = {$urandom, $urandom};
        {m0.awlen, m0.awvalid, m0.wlast, m0.wvalid, m0.bready} = 12'($urandom);
        {m1.awvalid, m1.wvalid, m1.bready} = 3'($urandom);
        {s.awready, s.wready, s.bvalid, s.bresp} = 5'($urandom);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (reset) begin
      check("rst_quiet", {s.arvalid, s.rready, m0.arready, m1.arready, m0.rvalid, m1.rvalid}, 6'b0);
      {busy, aph, pend} = '0;
      {starve, left, ar_wait} = '0;
      sq.delete();
    end else begin
      check("wr_aw_fwd", {s.awaddr, s.awlen, s.awvalid}, {m0.awaddr, m0.awlen, m0.awvalid});
      check("wr_w_fwd", {s.wdata, s.wlast, s.wvalid, s.bready}, {m0.wdata, m0.wlast, m0.wvalid, m0.bready});
      check("wr_bwd", {m0.awready, m0.wready, m0.bvalid, m0.bresp}, {s.awready, s.wready, s.bvalid, s.bresp});
      check("m1_wr_tie", {m1.awready, m1.wready, m1.bvalid}, 3'b0);
      if (pend) check("ar_stable", {s.arvalid, s.araddr, s.arlen}, {1'b1, pa, pl});
      if (!busy) begin
        check("idle_quiet", {s.arvalid, s.rready, m0.arready, m1.arready, m0.rvalid, m1.rvalid}, 6'b0);
        if (!m0.arvalid) starve = 0;
        if (m0.arvalid || m1.arvalid) begin
          win = !(m0.arvalid && (!m1.arvalid || starve == LIMIT));
          if (!win) starve = 0;
          else if (m0.arvalid && starve < LIMIT) starve++;
          {exp_addr, exp_len} = win ? {m1.araddr, m1.arlen} : {m0.araddr, m0.arlen};
          gnt_log.push_back(win);
          {busy, aph} = 2'b11;
        end
      end else if (aph) begin
        check("s_arvalid", s.arvalid, 1'b1);
        check("s_ar", {s.araddr, s.arlen}, {exp_addr, exp_len});
        check("m_arready", {m0.arready, m1.arready}, win ? {1'b0, s.arready} : {s.arready, 1'b0});
        check("addr_no_r", {s.rready, m0.rvalid, m1.rvalid}, 3'b0);
        if (s.arready) begin
          aph = 0;
          left = int'(exp_len) + 1;
        end
      end else begin
        check("data_no_ar", {s.arvalid, m0.arready, m1.arready}, 3'b0);
        if (win) begin
          check("r_route_m1", {m1.rvalid, m0.rvalid, s.rready}, {s.rvalid, 1'b0, m1.rready});
          if (s.rvalid) check("rdata_m1", m1.rdata, s.rdata);
        end else begin
          check("r_route_m0", {m0.rvalid, m1.rvalid, s.rready}, {s.rvalid, 1'b0, m0.rready});
          if (s.rvalid) check("rdata_m0", m0.rdata, s.rdata);
        end
        if (s.rvalid && s.rready) begin
          left--;
          if (win) beats1++;
          else beats0++;
          if (left == 0) busy = 0;
        end
      end
      if (m0.arvalid && m0.arready && q0.size() != 0) void'(q0.pop_front());
      if (m1.arvalid && m1.arready && q1.size() != 0) void'(q1.pop_front());
      if (s.arvalid && s.arready) begin
        sq.push_back('{s.arlen, 8'd0, s.araddr[23:0]});
        last_wait = ar_wait;
        ar_wait = 0;
      end else if (s.arvalid) ar_wait++;
      if (s.rvalid && s.rready) begin
        if (sq.size() == 0) check("beat_no_burst", sq.size(), 1);
        else if (sq[0].beat == sq[0].len) begin
          check("burst_end", left, 0);
          void'(sq.pop_front());
        end else sq[0].beat = sq[0].beat + 8'd1;
      end
      pend = s.arvalid && !s.arready;
      {pa, pl} = {s.araddr, s.arlen};
    end
  end
  task automatic push(input bit m, input logic [31:0] addr, input logic [7:0] len);
    req_t r;
    r.addr = addr;
    r.len = len;
    if (m) q1.push_back(r);
    else q0.push_back(r);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic drain(input string tag);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while ((q0.size() != 0 || q1.size() != 0 || busy) && n < 5000);
    check({tag, "_drain"}, n < 5000, 1'b1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0, b1, sum0, sum1, n;
    logic [7:0] l;
    tick(2);
    check("rst_state", dut.state_q, ARB_IDLE);
    check("rst_grant", dut.grant_q, GRANT_M0);
    check("rst_counts", {dut.starve_q, dut.beat_q, dut.len_q}, '0);
    reset = 0;
    tick(2);
    b0 = beats0; b1 = beats1; gnt_log.delete();
    push(1, 32'h1000_0000, 8'd63);
    drain("r026");
    check("r026_m1_beats", beats1 - b1, 64);
    check("r026_m0_beats", beats0 - b0, 0);
    check("r026_grant", {gnt_log.size(), gnt_log[0]}, {32'd1, 1'b1});
    gnt_log.delete();
    l = 8'($urandom_range(0, 15));
    push(1, $urandom, 8'd63);
    push(0, $urandom, l);
    drain("r027");
    check("r027_count", gnt_log.size(), 2);
    check("r027_order", {gnt_log[0], gnt_log[1]}, 2'b10);
    gnt_log.delete(); b0 = beats0;
    for (int i = 0; i < 6; i++) push(1, $urandom, 8'($urandom_range(0, 7)));
    push(0, 32'h0000_4000, 8'd7);
    drain("r028");
    check("r028_count", gnt_log.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("r028_order%0d", i), gnt_log[i], i != LIMIT);
    check("r028_m0_beats", beats0 - b0, 8);
    stall = 1; b0 = beats0;
    push(0, 32'h2000_0040, 8'd3);
    drain("r029");
    stall = 0;
    check("r029_stall", last_wait, 10);
    check("r029_beats", beats0 - b0, 4);
    b0 = beats0; b1 = beats1; sum0 = 0; sum1 = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (q0.size() < 2 && $urandom_range(0, 7) == 0) begin
        l = 8'($urandom_range(0, 15));
        sum0 += int'(l) + 1;
        push(0, $urandom, l);
      end
      if (q1.size() < 2 && $urandom_range(0, 5) == 0) begin
        l = (i == 200) ? 8'd255 : 8'($urandom_range(0, 31));
        sum1 += int'(l) + 1;
        push(1, $urandom, l);
      end
    end
    drain("rand");
    check("rand_m0_beats", beats0 - b0, sum0);
    check("rand_m1_beats", beats1 - b1, sum1);
    b1 = beats1; n = 0;
    push(1, 32'h1000_0000, 8'd63);
    while (beats1 - b1 < 20 && n < 2000) begin
      tick(1);
      n++;
    end
    check("r030_reach20", beats1 - b1, 20);
    reset = 1;
    q0.delete(); q1.delete();
    tick(1);
    check("r030_state", dut.state_q, ARB_IDLE);
    check("r030_beat", dut.beat_q, 8'd0);
    tick(1);
    reset = 0;
    b1 = beats1;
    tick(10);
    check("r030_no_residual", beats1 - b1, 0);
    b0 = beats0;
    push(0, 32'h3000_0000, 8'd11);
    drain("r030_fresh");
    check("r030_m0_beats", beats0 - b0, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
